// File: rtl/uart_buffer_ctrl.sv
// Host-side buffer controller for a UART: a TX FIFO drained by a small send/wait
// state machine, and a single-entry RX holding register with overrun detection.
module uart_buffer_ctrl #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       tx_full,
  output logic       tx_empty,
  output logic       tx_busy,
  output logic       rx_valid,
  output logic       rx_overrun,
  output logic       tx_overflow,
  input  logic       err_clr,
  output logic [7:0] uart_tx_data,
  output logic       uart_tx_send,
  input  logic       uart_tx_finish,
  input  logic       uart_rx_flag,
  input  logic [7:0] uart_rx_data,
  output logic       uart_rx_flag_clr
);

  localparam int DATA_W = 8;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [1:0]        state;
  logic              push;
  logic              pop;
  logic              rx_armed;
  logic              rx_capture;

  assign tx_full      = (count == CNT_W'(FIFO_DEPTH));
  assign tx_empty     = (count == '0);
  assign tx_busy      = (state != ST_IDLE);
  assign uart_tx_send = (state == ST_SEND);
  assign push         = wr_en && !tx_full;
  assign pop          = (state == ST_IDLE) && !tx_empty;
  assign rx_capture   = uart_rx_flag && rx_armed;

  // Storage is data-only; validity is tracked entirely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      tx_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      // A rejected write is flagged even when a pop frees a slot in the same cycle.
      if (wr_en && tx_full) tx_overflow <= 1'b1;
      else if (err_clr)     tx_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      uart_tx_data <= '0;
    end else begin
      case (state)
        ST_IDLE: if (pop) begin
          uart_tx_data <= fifo_mem[rd_ptr];
          state        <= ST_SEND;
        end
        ST_SEND: state <= ST_WAIT;
        ST_WAIT: if (uart_tx_finish) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A level-high flag is taken once; the flag must be seen low before the next byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_armed         <= 1'b1;
      uart_rx_flag_clr <= 1'b0;
      rd_data          <= '0;
      rx_valid         <= 1'b0;
      rx_overrun       <= 1'b0;
    end else begin
      uart_rx_flag_clr <= rx_capture;
      if (rx_capture)         rx_armed <= 1'b0;
      else if (!uart_rx_flag) rx_armed <= 1'b1;

      if (rx_capture && (!rx_valid || rd_en)) begin
        rd_data  <= uart_rx_data;
        rx_valid <= 1'b1;
      end else if (!rx_capture && rd_en && rx_valid) begin
        rx_valid <= 1'b0;
      end

      if (rx_capture && rx_valid && !rd_en) rx_overrun <= 1'b1;
      else if (err_clr)                     rx_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_buffer_ctrl.sv
// Bench for uart_buffer_ctrl: directed scenarios followed by random traffic, checked
// against a transaction-level reference of the FIFO, sender and RX holding register.
module tb_uart_buffer_ctrl;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       tx_full, tx_empty, tx_busy, rx_valid, rx_overrun, tx_overflow;
  logic       err_clr = 1'b0;
  logic [7:0] uart_tx_data;
  logic       uart_tx_send;
  logic       uart_tx_finish = 1'b0;
  logic       uart_rx_flag = 1'b0;
  logic [7:0] uart_rx_data = '0;
  logic       uart_rx_flag_clr;

  always #5 clk = ~clk;

  uart_buffer_ctrl #(.FIFO_DEPTH(DEPTH), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .tx_full(tx_full), .tx_empty(tx_empty), .tx_busy(tx_busy),
    .rx_valid(rx_valid), .rx_overrun(rx_overrun), .tx_overflow(tx_overflow),
    .err_clr(err_clr), .uart_tx_data(uart_tx_data), .uart_tx_send(uart_tx_send),
    .uart_tx_finish(uart_tx_finish), .uart_rx_flag(uart_rx_flag),
    .uart_rx_data(uart_rx_data), .uart_rx_flag_clr(uart_rx_flag_clr)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference: m_cnt bytes waiting, sender phase (0 free, 1 start pulse, 2 on the line)
  int         m_cnt = 0;
  int         m_phase = 0;
  bit         m_ovf = 0, m_armed = 1, m_rxv = 0, m_ovr = 0, m_clr = 0;
  logic [7:0] m_rd = '0;
  logic [7:0] m_hold = '0;
  logic [7:0] exp_tx[$];
  bit         p_flag = 0;
  logic [7:0] p_data = '0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_phase = 0; m_ovf = 0; m_armed = 1; m_rxv = 0; m_ovr = 0; m_clr = 0;
    m_rd = '0; m_hold = '0; p_flag = 0;
    exp_tx.delete();
  endtask

  task automatic model_step(input bit we, input logic [7:0] wd, input bit rde, input bit fin,
                            input bit eclr, input bit flag, input logic [7:0] rxd);
    bit full, take, cap, seen_clr;
    full = (m_cnt == DEPTH);
    take = (m_phase == 0) && (m_cnt > 0);
    if (we && full) m_ovf = 1;
    else if (eclr)  m_ovf = 0;
    if (we && !full) begin
      m_cnt++;
      exp_tx.push_back(wd);
    end
    if (take) m_cnt--;
    case (m_phase)
      0: m_phase = take ? 1 : 0;
      1: m_phase = 2;
      default: m_phase = fin ? 0 : 2;
    endcase
    cap = flag && m_armed;
    seen_clr = m_clr;
    m_clr = cap;
    if (cap) m_armed = 0;
    else if (!flag) m_armed = 1;
    if (cap && m_rxv && !rde) m_ovr = 1;
    else if (eclr) m_ovr = 0;
    if (cap && (!m_rxv || rde)) begin
      m_rd = rxd;
      m_rxv = 1;
    end else if (!cap && rde) begin
      m_rxv = 0;
    end
    // The receiver drops its flag once it has seen the clear pulse.
    if (seen_clr) p_flag = 0;
  endtask

  task automatic cycle(input bit we, input logic [7:0] wd, input bit rde, input bit fin,
                       input bit eclr);
    wr_en = we; wr_data = wd; rd_en = rde; uart_tx_finish = fin; err_clr = eclr;
    uart_rx_flag = p_flag; uart_rx_data = p_data;
    @(posedge clk);
    model_step(we, wd, rde, fin, eclr, p_flag, p_data);
    #1;
  endtask

  task automatic idle(input int n, input bit fin_when_waiting);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, fin_when_waiting && (m_phase == 2), 1'b0);
  endtask

  task automatic rx_send(input logic [7:0] b);
    p_flag = 1;
    p_data = b;
  endtask

  // Monitor: flags every cycle, transmitted bytes through the scoreboard queue.
  initial begin
    forever begin
      @(negedge clk);
      chk("tx_empty", tx_empty, m_cnt == 0);
      chk("tx_full", tx_full, m_cnt == DEPTH);
      chk("tx_busy", tx_busy, m_phase != 0);
      chk("tx_send", uart_tx_send, m_phase == 1);
      chk("tx_overflow", tx_overflow, m_ovf);
      chk("rx_valid", rx_valid, m_rxv);
      chk("rd_data", rd_data, m_rd);
      chk("rx_overrun", rx_overrun, m_ovr);
      chk("rx_flag_clr", uart_rx_flag_clr, m_clr);
      if (uart_tx_send) begin
        if (exp_tx.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL tx_order: got send of %h expected no send at %0t", uart_tx_data, $time);
        end else begin
          m_hold = exp_tx.pop_front();
          chk("tx_data", uart_tx_data, m_hold);
        end
      end else if (m_phase == 2) begin
        chk("tx_hold", uart_tx_data, m_hold);
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_tx_empty", tx_empty, 1'b1);
    chk("rst_tx_data", uart_tx_data, 8'h00);
    chk("rst_rd_data", rd_data, 8'h00);

    // Single byte: start pulse two edges after the write, byte held until finish.
    cycle(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    chk("a5_no_send_yet", uart_tx_send, 1'b0);
    idle(1, 0);
    chk("a5_send", uart_tx_send, 1'b1);
    chk("a5_data", uart_tx_data, 8'hA5);
    idle(4, 0);
    chk("a5_busy", tx_busy, 1'b1);
    chk("a5_held", uart_tx_data, 8'hA5);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("a5_idle", tx_busy, 1'b0);

    // Fill: one byte on the line, eight queued, the ninth is rejected.
    cycle(1'b1, 8'hF0, 1'b0, 1'b0, 1'b0);
    idle(2, 0);
    for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    chk("fill_full", tx_full, 1'b1);
    chk("fill_no_ovf", tx_overflow, 1'b0);
    cycle(1'b1, 8'h09, 1'b0, 1'b0, 1'b0);
    chk("fill_ovf", tx_overflow, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("fill_ovf_clr", tx_overflow, 1'b0);
    idle(60, 1);
    chk("fill_drained", 8'(exp_tx.size()), 8'd0);
    chk("fill_empty", tx_empty, 1'b1);

    // RX capture and read.
    rx_send(8'h3C);
    idle(3, 0);
    chk("rx_3c_valid", rx_valid, 1'b1);
    chk("rx_3c_data", rd_data, 8'h3C);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("rx_read", rx_valid, 1'b0);

    // Overrun: second byte while the first is unread.
    idle(2, 0);
    rx_send(8'h3C);
    idle(3, 0);
    rx_send(8'h7E);
    idle(3, 0);
    chk("ovr_keep", rd_data, 8'h3C);
    chk("ovr_flag", rx_overrun, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("ovr_clr", rx_overrun, 1'b0);

    // Capture coincident with a read replaces the byte without overrun.
    idle(2, 0);
    rx_send(8'h55);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("cap_rd_data", rd_data, 8'h55);
    chk("cap_rd_valid", rx_valid, 1'b1);
    chk("cap_rd_ovr", rx_overrun, 1'b0);
    idle(3, 0);

    // Reset while a byte is on the line and three more are queued.
    cycle(1'b1, 8'hB1, 1'b0, 1'b0, 1'b0);
    idle(2, 0);
    cycle(1'b1, 8'hB2, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'hB3, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'hB4, 1'b0, 1'b0, 1'b0);
    wr_en = 1'b0; rd_en = 1'b0; uart_tx_finish = 1'b0; err_clr = 1'b0; uart_rx_flag = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_busy", tx_busy, 1'b0);
    chk("mid_rst_empty", tx_empty, 1'b1);
    chk("mid_rst_tx_data", uart_tx_data, 8'h00);
    chk("mid_rst_rd_data", rd_data, 8'h00);
    chk("mid_rst_rx_valid", rx_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(10, 1);
    cycle(1'b1, 8'hC7, 1'b0, 1'b0, 1'b0);
    idle(6, 1);

    // Random traffic, including stray finish pulses and reads with nothing held.
    for (int i = 0; i < 4000; i++) begin
      bit fin;
      if (m_phase == 2) fin = ($urandom_range(0, 3) == 0);
      else              fin = ($urandom_range(0, 19) == 0);
      if (!p_flag && m_armed && $urandom_range(0, 5) == 0) rx_send(8'($urandom));
      cycle($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 3) == 0, fin,
            $urandom_range(0, 29) == 0);
    end
    idle(80, 1);
    chk("final_drained", 8'(exp_tx.size()), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
